// File: rtl/maxpool1.sv
// 2x2 / stride-2 max pooling of a binary multi-channel feature map.
// Captures a whole map, then writes one pooled output row per cycle, with a finished/reply handshake on both sides.
module maxpool1 #(
  parameter int IN_DIM   = 28,
  parameter int CHANNELS = 2,
  localparam int OUT_DIM = IN_DIM / 2,
  localparam int IN_W    = CHANNELS * IN_DIM * IN_DIM,
  localparam int OUT_W   = CHANNELS * OUT_DIM * OUT_DIM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  featuremap_in,
  input  logic             finished_from_prev_device,
  output logic             reply_to_prev_device,
  input  logic             reply_from_next_device,
  output logic [OUT_W-1:0] pooled_out,
  output logic             finished_for_next_device
);

  localparam int ROW_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IN_CH = IN_DIM * IN_DIM;
  localparam int OUT_CH = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    POOL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ROW_W-1:0]  row, row_next;
  logic [IN_W-1:0]   map_buf;
  logic [OUT_W-1:0]  pooled_next;
  logic              capture;

  // Binary data: the max of a window is the OR of its bits.
  function automatic logic win_max(input logic a, input logic b, input logic c, input logic d);
    return a | b | c | d;
  endfunction

  always_comb begin
    state_next  = state;
    row_next    = row;
    pooled_next = pooled_out;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (finished_from_prev_device) begin
          capture     = 1'b1;
          pooled_next = '0;
          state_next  = ACK;
        end
      end
      ACK: begin
        row_next   = '0;
        state_next = POOL;
      end
      POOL: begin
        for (int c = 0; c < CHANNELS; c++) begin
          for (int r = 0; r < OUT_DIM; r++) begin
            if (row == ROW_W'(r)) begin
              for (int k = 0; k < OUT_DIM; k++) begin
                pooled_next[c*OUT_CH + r*OUT_DIM + k] = win_max(
                  map_buf[c*IN_CH + (2*r)*IN_DIM   + 2*k],
                  map_buf[c*IN_CH + (2*r)*IN_DIM   + 2*k + 1],
                  map_buf[c*IN_CH + (2*r+1)*IN_DIM + 2*k],
                  map_buf[c*IN_CH + (2*r+1)*IN_DIM + 2*k + 1]);
              end
            end
          end
        end
        if (row == ROW_W'(OUT_DIM - 1)) begin
          row_next   = '0;
          state_next = DONE;
        end else begin
          row_next = row + ROW_W'(1);
        end
      end
      DONE: begin
        if (reply_from_next_device) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      map_buf    <= '0;
      pooled_out <= '0;
    end else begin
      state      <= state_next;
      row        <= row_next;
      pooled_out <= pooled_next;
      if (capture) map_buf <= featuremap_in;
    end
  end

  assign reply_to_prev_device     = (state == ACK);
  assign finished_for_next_device = (state == DONE);

endmodule
